// File: rtl/fp_convert_issue_buffer_pkg.sv
// Shared types and defaults for the int-to-float conversion issue buffer.
// Holds the FSM state type, the response layout and default widths.
package fp_convert_issue_buffer_pkg;

    localparam int unsigned DefLatency = 6;
    localparam int unsigned DefDepth   = 8;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefTagW    = 4;
    localparam int unsigned DefCreditW = $clog2(DefDepth + 1);

    typedef enum logic {StDrain, StRun} state_e;

    typedef struct packed {
        logic [DefTagW-1:0]  tag;
        logic [DefDataW-1:0] data;
    } resp_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with asynchronous active-high reset.
// Depth must be a power of two; pointers carry one extra wrap bit.
module fp_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/fp_convert_issue_buffer.sv
// Credit-gated issue and in-order result buffering around a fixed-latency,
// non-stallable int-to-float conversion unit.
module fp_convert_issue_buffer
    import fp_convert_issue_buffer_pkg::*;
#(
    parameter int unsigned LATENCY = DefLatency,
    parameter int unsigned DEPTH   = DefDepth,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned TAG_W   = DefTagW
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              unit_go_o,
    output logic [DATA_W-1:0] unit_operand_o,
    input  logic              unit_done_i,
    input  logic [DATA_W-1:0] unit_result_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_data_o,
    output logic [TAG_W-1:0]  resp_tag_o,
    output logic              err_o
);

    localparam int unsigned CreditW = $clog2(DEPTH + 1);
    localparam int unsigned CntW    = $clog2(LATENCY + 1);
    localparam int unsigned ResW    = TAG_W + DATA_W;

    state_e               state_q;
    logic [CntW-1:0]      drain_cnt_q;
    logic [CreditW-1:0]   credits_q, credits_d;
    logic                 err_q, err_d;

    logic                 issue, capture, resp_pop;
    logic                 tag_empty, tag_full, res_empty, res_full, res_push;
    logic [TAG_W-1:0]     tag_head;
    logic [ResW-1:0]      res_head;

    assign req_ready_o    = (state_q == StRun) && (credits_q != '0);
    assign issue          = req_valid_i && req_ready_o;
    assign unit_go_o      = issue;
    assign unit_operand_o = req_data_i;

    // Done pulses during drain belong to pre-reset traffic and are discarded.
    assign capture  = (state_q == StRun) && unit_done_i;
    assign res_push = capture && !tag_empty;

    assign resp_valid_o = !res_empty;
    assign resp_pop     = resp_valid_o && resp_ready_i;
    assign resp_tag_o   = res_head[ResW-1:DATA_W];
    assign resp_data_o  = res_head[DATA_W-1:0];
    assign err_o        = err_q;

    always_comb begin
        credits_d = credits_q - CreditW'(issue) + CreditW'(resp_pop);
        err_d     = err_q || (capture && tag_empty);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StDrain;
            drain_cnt_q <= CntW'(LATENCY);
        end else begin
            case (state_q)
                StDrain: begin
                    if (drain_cnt_q == '0) state_q <= StRun;
                    else                   drain_cnt_q <= drain_cnt_q - CntW'(1);
                end
                StRun:   state_q <= StRun;
                default: state_q <= StDrain;
            endcase
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            credits_q <= CreditW'(DEPTH);
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    fp_sync_fifo #(
        .Width (TAG_W),
        .Depth (DEPTH)
    ) u_tag_fifo (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (issue),
        .wdata_i (req_tag_i),
        .pop_i   (res_push),
        .rdata_o (tag_head),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    fp_sync_fifo #(
        .Width (ResW),
        .Depth (DEPTH)
    ) u_res_fifo (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (res_push),
        .wdata_i ({tag_head, unit_result_i}),
        .pop_i   (resp_pop),
        .rdata_o (res_head),
        .empty_o (res_empty),
        .full_o  (res_full)
    );

    credit_bounds_a: assert property (@(posedge clock_i) disable iff (reset_i)
        credits_q <= CreditW'(DEPTH));
    credit_underflow_a: assert property (@(posedge clock_i) disable iff (reset_i)
        !(issue && credits_q == '0));
    credit_overflow_a: assert property (@(posedge clock_i) disable iff (reset_i)
        !(resp_pop && !issue && credits_q == CreditW'(DEPTH)));
    no_full_push_a: assert property (@(posedge clock_i) disable iff (reset_i)
        !((res_push && res_full) || (issue && tag_full)));

endmodule

// File: tb/tb_fp_convert_issue_buffer.sv
// Scoreboard bench for fp_convert_issue_buffer with a behavioural
// fixed-latency conversion unit that keeps running through reset.
module tb_fp_convert_issue_buffer;
    import fp_convert_issue_buffer_pkg::*;

    localparam int unsigned L  = 6;
    localparam int unsigned D  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_ready;
    logic [DW-1:0] req_data = '0;
    logic [TW-1:0] req_tag = '0;
    logic          unit_go, unit_done;
    logic [DW-1:0] unit_operand, unit_result;
    logic          resp_valid, resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic [TW-1:0] resp_tag;
    logic          err;
    logic          force_done = 1'b0;
    logic [DW-1:0] force_result = '0;

    int    n_checks = 0;
    int    n_pass = 0;
    resp_t exp_q[$];

    logic [L-1:0]  pv = '0;
    logic [DW-1:0] pd [L];

    always #5 clock = ~clock;

    fp_convert_issue_buffer #(
        .LATENCY (L),
        .DEPTH   (D),
        .DATA_W  (DW),
        .TAG_W   (TW)
    ) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .req_tag_i      (req_tag),
        .unit_go_o      (unit_go),
        .unit_operand_o (unit_operand),
        .unit_done_i    (unit_done),
        .unit_result_i  (unit_result),
        .resp_valid_o   (resp_valid),
        .resp_ready_i   (resp_ready),
        .resp_data_o    (resp_data),
        .resp_tag_o     (resp_tag),
        .err_o          (err)
    );

    // Signed int32 to IEEE single, truncating extra mantissa bits.
    function automatic logic [31:0] i2f(input logic [31:0] x);
        logic        s;
        logic [31:0] m, mant;
        int          p;
        if (x == 32'd0) return 32'd0;
        s = x[31];
        m = s ? (~x + 32'd1) : x;
        p = 31;
        while (p > 0 && !m[p]) p--;
        if (p > 23) mant = m >> (p - 23);
        else        mant = m << (23 - p);
        return {s, 8'(127 + p), mant[22:0]};
    endfunction

    // Conversion unit model: done exactly L cycles after go, no reset.
    always @(posedge clock) begin
        pv    <= {pv[L-2:0], unit_go};
        pd[0] <= i2f(unit_operand);
        for (int k = 1; k < L; k++) pd[k] <= pd[k-1];
    end
    assign unit_done   = pv[L-1] | force_done;
    assign unit_result = force_done ? force_result : pd[L-1];

    // Response monitor: every accepted response is popped from the scoreboard.
    always begin
        resp_t e;
        @(negedge clock);
        #2;
        if (!reset && resp_valid && resp_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL resp_unexpected: got tag=%0h data=%08h, want no response",
                         resp_tag, resp_data);
            end else begin
                e = exp_q.pop_front();
                if ({resp_tag, resp_data} !== e)
                    $display("FAIL resp_order: got tag=%0h data=%08h, want tag=%0h data=%08h",
                             resp_tag, resp_data, e.tag, e.data);
                else n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic sb_issue();
        resp_t e;
        if (req_valid && req_ready) begin
            e.tag  = req_tag;
            e.data = i2f(req_data);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain_wait(output int left);
        left = exp_q.size();
        for (int i = 0; i < 60 && left != 0; i++) begin
            step();
            #3;
            left = exp_q.size();
        end
    endtask

    task automatic test_reset();
        int left;
        reset = 1'b1; req_valid = 1'b1; req_data = 32'd100; req_tag = 4'hA;
        resp_ready = 1'b1; force_done = 1'b0; force_result = 32'hDEAD_BEEF;
        repeat (3) step();
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (unit_go !== 1'b0) $display("FAIL rst_unit_go: got %b want 0", unit_go); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        step();
        reset = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            if (k > 0) step();
            force_done = (k == 2 || k == 4);
            #1;
            n_checks++;
            if (req_ready !== 1'(k == 7))
                $display("FAIL drain_ready_c%0d: got %b want %b", k, req_ready, (k == 7));
            else n_pass++;
            n_checks++;
            if (unit_go !== 1'(k == 7))
                $display("FAIL drain_go_c%0d: got %b want %b", k, unit_go, (k == 7));
            else n_pass++;
            sb_issue();
        end
        step();
        req_valid = 1'b0; force_done = 1'b0;
        #1;
        n_checks++; if (err !== 1'b0) $display("FAIL drain_err: got %b want 0", err); else n_pass++;
        drain_wait(left);
        n_checks++; if (left != 0) $display("FAIL reset_drain: got %0d pending want 0", left); else n_pass++;
    endtask

    task automatic test_single();
        int left, early = 0;
        step();
        req_valid = 1'b1; req_data = 32'h0000_0005; req_tag = 4'd3; resp_ready = 1'b1;
        #1;
        n_checks++; if (unit_go !== 1'b1) $display("FAIL single_go: got %b want 1", unit_go); else n_pass++;
        n_checks++; if (unit_operand !== 32'd5) $display("FAIL single_operand: got %08h want 00000005", unit_operand); else n_pass++;
        sb_issue();
        for (int k = 1; k <= 7; k++) begin
            step();
            req_valid = 1'b0;
            #1;
            if (k < 7) begin
                if (resp_valid !== 1'b0) early++;
            end else begin
                n_checks++; if (resp_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", resp_valid); else n_pass++;
                n_checks++; if (resp_data !== 32'h40A0_0000) $display("FAIL single_data: got %08h want 40a00000", resp_data); else n_pass++;
                n_checks++; if (resp_tag !== 4'd3) $display("FAIL single_tag: got %0h want 3", resp_tag); else n_pass++;
            end
        end
        n_checks++; if (early != 0) $display("FAIL single_early: got %0d early cycles want 0", early); else n_pass++;
        drain_wait(left);
        n_checks++; if (left != 0) $display("FAIL single_drain: got %0d pending want 0", left); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first = -1, last = -1, cnt = 0, stall = 0, left;
        resp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (c < 20) begin
                req_valid = 1'b1; req_data = $urandom; req_tag = 4'(c);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c < 20) begin
                if (req_ready !== 1'b1) stall++;
                sb_issue();
            end
            if (resp_valid === 1'b1) begin
                cnt++;
                if (first < 0) first = c;
                last = c;
            end
        end
        n_checks++; if (stall != 0) $display("FAIL b2b_stall: got %0d stalls want 0", stall); else n_pass++;
        n_checks++; if (cnt != 20) $display("FAIL b2b_count: got %0d want 20", cnt); else n_pass++;
        n_checks++; if (first != 7) $display("FAIL b2b_first: got %0d want 7", first); else n_pass++;
        n_checks++; if (last != 26) $display("FAIL b2b_last: got %0d want 26", last); else n_pass++;
        drain_wait(left);
        n_checks++; if (left != 0) $display("FAIL b2b_drain: got %0d pending want 0", left); else n_pass++;
    endtask

    task automatic test_backpressure();
        int idx = 0, left;
        resp_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            req_valid = 1'b1; req_data = 32'(1000 + idx * 3); req_tag = 4'(idx);
            #1;
            if (req_ready) begin sb_issue(); idx++; end
            if (c == 11) begin
                n_checks++; if (idx != 8) $display("FAIL bp_accept12: got %0d want 8", idx); else n_pass++;
                n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", req_ready); else n_pass++;
            end
        end
        n_checks++; if (idx != 8) $display("FAIL bp_accept20: got %0d want 8", idx); else n_pass++;
        step();
        resp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_pop_cycle: got %b want 0", req_ready); else n_pass++;
        step();
        resp_ready = 1'b0; req_data = 32'(1000 + idx * 3); req_tag = 4'(idx);
        #1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL bp_credit_back: got %b want 1", req_ready); else n_pass++;
        if (req_ready) begin sb_issue(); idx++; end
        step();
        req_data = 32'(1000 + idx * 3); req_tag = 4'(idx);
        #1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_one_only: got %b want 0", req_ready); else n_pass++;
        resp_ready = 1'b1;
        for (int c = 0; c < 40 && idx < 12; c++) begin
            step();
            req_data = 32'(1000 + idx * 3); req_tag = 4'(idx);
            #1;
            if (req_ready) begin sb_issue(); idx++; end
        end
        step();
        req_valid = 1'b0;
        n_checks++; if (idx != 12) $display("FAIL bp_total: got %0d want 12", idx); else n_pass++;
        drain_wait(left);
        n_checks++; if (left != 0) $display("FAIL bp_drain: got %0d pending want 0", left); else n_pass++;
    endtask

    task automatic test_spurious();
        int rv = 0, idx = 0, left;
        resp_ready = 1'b1; req_valid = 1'b0;
        step();
        force_done = 1'b1; force_result = 32'h1234_5678;
        #1;
        n_checks++; if (err !== 1'b0) $display("FAIL spur_err_before: got %b want 0", err); else n_pass++;
        step();
        force_done = 1'b0;
        #1;
        n_checks++; if (err !== 1'b1) $display("FAIL spur_err_rise: got %b want 1", err); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            step();
            #1;
            if (resp_valid !== 1'b0) rv++;
        end
        n_checks++; if (rv != 0) $display("FAIL spur_resp: got %0d valid cycles want 0", rv); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL spur_err_sticky: got %b want 1", err); else n_pass++;
        resp_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            req_valid = (idx < 9); req_data = 32'(-(idx * 77 + 1)); req_tag = 4'(idx + 5);
            #1;
            if (req_valid && req_ready) begin sb_issue(); idx++; end
        end
        n_checks++; if (idx != 8) $display("FAIL spur_credits: got %0d accepted want 8", idx); else n_pass++;
        resp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 9; c++) begin
            step();
            req_data = 32'(-(idx * 77 + 1)); req_tag = 4'(idx + 5);
            #1;
            if (req_ready) begin sb_issue(); idx++; end
        end
        step();
        req_valid = 1'b0;
        drain_wait(left);
        n_checks++; if (left != 0) $display("FAIL spur_drain: got %0d pending want 0", left); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int stale = 0, first_ready = -1, left;
        resp_ready = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            step();
            req_valid = (c < 2) || (c >= 5);
            req_data = 32'(c * 11 + 2); req_tag = 4'(c);
            #1;
            sb_issue();
            if (c == 8) begin
                n_checks++; if (resp_valid !== 1'b1) $display("FAIL mid_buffered: got %b want 1", resp_valid); else n_pass++;
            end
        end
        step();
        reset = 1'b1;
        #1;
        exp_q.delete();
        n_checks++; if (req_ready !== 1'b0) $display("FAIL mid_rst_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (unit_go !== 1'b0) $display("FAIL mid_rst_go: got %b want 0", unit_go); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", err); else n_pass++;
        step();
        req_valid = 1'b0;
        step();
        reset = 1'b0; resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            #1;
            if (resp_valid !== 1'b0) stale++;
            if (req_ready === 1'b1 && first_ready < 0) first_ready = k;
        end
        n_checks++; if (stale != 0) $display("FAIL mid_stale: got %0d valid cycles want 0", stale); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL mid_err: got %b want 0", err); else n_pass++;
        n_checks++; if (first_ready != 7) $display("FAIL mid_drain_len: got %0d want 7", first_ready); else n_pass++;
        step();
        req_valid = 1'b1; req_data = 32'hFFFF_FFFF; req_tag = 4'd9;
        #1;
        n_checks++; if (unit_go !== 1'b1) $display("FAIL mid_resume_go: got %b want 1", unit_go); else n_pass++;
        sb_issue();
        step();
        req_valid = 1'b0;
        drain_wait(left);
        n_checks++; if (left != 0) $display("FAIL mid_drain: got %0d pending want 0", left); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
